// File: rtl/ecc_pkg.sv
// Shared constants and types for the ECC operand loader.
// Holds operand geometry, FSM states and error-flag bit positions.
package ecc_pkg;

    localparam int SIZE        = 32;
    localparam int NIB         = 4;
    localparam int NUM_NIBBLES = SIZE / NIB;

    localparam int ERR_PRIME = 0;
    localparam int ERR_PX    = 1;
    localparam int ERR_PY    = 2;
    localparam int ERR_K     = 3;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        CHECK,
        VALID
    } state_t;

endpackage

// File: rtl/ecc_operand_loader_if.sv
// Serial operand input and parallel operand output bundle.
// master drives nibbles and i_ready; slave is the loader.
interface ecc_operand_loader_if #(
    parameter int SIZE = ecc_pkg::SIZE,
    parameter int NIB  = ecc_pkg::NIB
);

    logic            i_start;
    logic [NIB-1:0]  a;
    logic [NIB-1:0]  prime;
    logic [NIB-1:0]  k;
    logic [NIB-1:0]  Px;
    logic [NIB-1:0]  Py;
    logic [SIZE-1:0] o_a;
    logic [SIZE-1:0] o_prime;
    logic [SIZE-1:0] o_k;
    logic [SIZE-1:0] o_px;
    logic [SIZE-1:0] o_py;
    logic            o_valid;
    logic            i_ready;
    logic [3:0]      o_err;
    logic            o_busy;

    modport master (
        output i_start, a, prime, k, Px, Py, i_ready,
        input  o_a, o_prime, o_k, o_px, o_py,
        input  o_valid, o_err, o_busy
    );

    modport slave (
        input  i_start, a, prime, k, Px, Py, i_ready,
        output o_a, o_prime, o_k, o_px, o_py,
        output o_valid, o_err, o_busy
    );

endinterface

// File: rtl/ecc_operand_check.sv
// Combinational range checks on an assembled operand set.
// Flags are only meaningful once the full set is loaded.
module ecc_operand_check #(
    parameter int SIZE = ecc_pkg::SIZE
) (
    input  logic [SIZE-1:0] prime,
    input  logic [SIZE-1:0] k,
    input  logic [SIZE-1:0] px,
    input  logic [SIZE-1:0] py,
    output logic [3:0]      err
);
    import ecc_pkg::*;

    always_comb begin
        err            = '0;
        err[ERR_PRIME] = ~prime[0] | (prime < SIZE'(3));
        err[ERR_PX]    = (px >= prime);
        err[ERR_PY]    = (py >= prime);
        err[ERR_K]     = (k == '0);
    end

endmodule

// File: rtl/ecc_operand_loader.sv
// Assembles five serial nibble streams into parallel operands,
// range-checks them and hands them to the core via valid/ready.
module ecc_operand_loader #(
    parameter int SIZE = ecc_pkg::SIZE,
    parameter int NIB  = ecc_pkg::NIB
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    ecc_operand_loader_if.slave  bus
);
    import ecc_pkg::*;

    localparam int NN = SIZE / NIB;
    localparam int CW = $clog2(NN);

    state_t        state;
    logic [CW-1:0] cnt;
    logic [3:0]    err;
    logic          hs;
    logic          wr_en;
    logic [CW-1:0] idx;

    ecc_operand_check #(.SIZE(SIZE)) u_check (
        .prime (bus.o_prime),
        .k     (bus.o_k),
        .px    (bus.o_px),
        .py    (bus.o_py),
        .err   (err)
    );

    assign hs = bus.o_valid & bus.i_ready;

    // Nibble 0 lands on a start from IDLE or on a back-to-back handshake.
    always_comb begin
        wr_en = 1'b0;
        idx   = '0;
        unique case (state)
            IDLE:    wr_en = bus.i_start;
            LOAD: begin
                wr_en = 1'b1;
                idx   = cnt;
            end
            VALID:   wr_en = hs & bus.i_start;
            default: wr_en = 1'b0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state       <= IDLE;
            cnt         <= '0;
            bus.o_valid <= 1'b0;
            bus.o_busy  <= 1'b0;
            bus.o_err   <= '0;
            bus.o_a     <= '0;
            bus.o_prime <= '0;
            bus.o_k     <= '0;
            bus.o_px    <= '0;
            bus.o_py    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.i_start) begin
                        cnt        <= CW'(1);
                        state      <= LOAD;
                        bus.o_busy <= 1'b1;
                    end
                end
                LOAD: begin
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(NN - 1)) begin
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    bus.o_err   <= err;
                    bus.o_valid <= 1'b1;
                    state       <= VALID;
                end
                VALID: begin
                    if (hs) begin
                        bus.o_valid <= 1'b0;
                        if (bus.i_start) begin
                            cnt   <= CW'(1);
                            state <= LOAD;
                        end else begin
                            cnt        <= '0;
                            state      <= IDLE;
                            bus.o_busy <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            if (wr_en) begin
                bus.o_a[int'(idx)*NIB +: NIB]     <= bus.a;
                bus.o_prime[int'(idx)*NIB +: NIB] <= bus.prime;
                bus.o_k[int'(idx)*NIB +: NIB]     <= bus.k;
                bus.o_px[int'(idx)*NIB +: NIB]    <= bus.Px;
                bus.o_py[int'(idx)*NIB +: NIB]    <= bus.Py;
            end
        end
    end

endmodule

// File: doc/ecc_operand_loader.md
ECC_OPERAND_LOADER -- requirements
Module: ecc_operand_loader

Interface
REQ-001 SHALL have parameter SIZE, default 32, meaning operand width in bits.
REQ-002 SHALL have parameter NIB, default 4, meaning serial nibble width; SIZE/NIB = 8 nibbles per operand.
REQ-003 SHALL have i_clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have i_rst  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have i_start  input  1  marks nibble 0 of a new operand set.
REQ-006 SHALL have a, prime, k, Px, Py  input  NIB each  serial operand nibbles, LSB nibble first.
REQ-007 SHALL have o_a, o_prime, o_k, o_px, o_py  output  SIZE each  assembled operands to the point-multiply core.
REQ-008 SHALL have o_valid  output  1  operand set complete and stable.
REQ-009 SHALL have i_ready  input  1  core accepts operand set.
REQ-010 SHALL have o_err  output  4  operand check flags, qualified by o_valid.
REQ-011 SHALL have o_busy  output  1  high in any state other than IDLE.

Function
REQ-012 SHALL implement FSM states IDLE, LOAD, CHECK, VALID.
REQ-013 IDLE: when i_start=1, SHALL write nibble 0 of all five inputs into bits [3:0], set nibble counter to 1, and go to LOAD.
REQ-014 LOAD: each cycle SHALL write the input nibbles into bits [4*cnt+3:4*cnt] and increment cnt; on cnt=7 write, go to CHECK.
REQ-015 i_start SHALL be ignored in LOAD and CHECK; counter and data are not restarted.
REQ-016 CHECK: one cycle; SHALL register o_err from the assembled operands, then go to VALID.
REQ-017 o_err[0] SHALL be 1 if prime is even or prime < 3; o_err[1] if Px >= prime; o_err[2] if Py >= prime; o_err[3] if k == 0; comparisons unsigned, full SIZE width.
REQ-018 VALID: o_valid=1; o_a..o_py and o_err SHALL stay constant until the handshake (o_valid & i_ready).
REQ-019 On handshake with i_start=0, SHALL go to IDLE next cycle; o_valid drops the cycle after the handshake.
REQ-020 On handshake with i_start=1 in the same cycle, SHALL capture nibble 0 and go directly to LOAD (back-to-back sets, no lost nibble).
REQ-021 i_start in VALID without i_ready SHALL be ignored.
REQ-022 Latency: i_start at cycle 0, nibble 7 at cycle 7, CHECK at cycle 8, o_valid first high at cycle 9.
REQ-023 Operand set SHALL be forwarded even when o_err != 0; the core decides on rejection.
REQ-024 Operand registers SHALL be written only in IDLE (on start) and LOAD; never in CHECK or VALID.

Reset
REQ-025 On i_rst=0, SHALL immediately force state IDLE, cnt=0, o_valid=0, o_busy=0, o_err=0, all operand outputs 0.
REQ-026 Reset mid-LOAD or in VALID SHALL discard the partial/pending set; first i_start after reset release starts a fresh set.

Structure
REQ-027 Shared package ecc_pkg SHALL hold SIZE, NIB, NUM_NIBBLES=8, FSM state typedef, and o_err bit-index constants.
REQ-028 Range checks SHALL live in one combinational sub-module ecc_operand_check (inputs: prime, k, Px, Py; output: 4-bit err).

Verification
REQ-029 Nominal: serial a=0x2, prime=0x11 (17), k=0x7, Px=0x5, Py=0x1, i_ready=1 -> o_valid at cycle 9 for 1 cycle, outputs exact, o_err=0.
REQ-030 Bad operands: prime=0x10, Px=0x10, Py=0x3, k=0 -> o_err=4'b1011.
REQ-031 Backpressure: i_ready=0 for 20 cycles with toggling i_start and nibble inputs -> o_valid held, outputs unchanged; release i_ready -> o_valid falls next cycle.
REQ-032 Back-to-back: i_ready and i_start both 1 in a VALID cycle, second set prime=0xFFFFFFFB -> second o_valid exactly 9 cycles after that handshake with correct values.
REQ-033 Reset mid-LOAD at nibble 4 -> all outputs 0 immediately; subsequent full set loads correctly with no residue of the aborted nibbles.
REQ-034 i_start pulses during LOAD -> ignored; assembled operands equal the originally started set.
